sram_rd_stream: RTL and testbench

Read-side sequencer for the 2048 x 32 activation/weight SRAM. On a `start` pulse it issues a programmable run of consecutive reads (`base_addr`, `len`) to the SRAM and drives the returned words out on a valid/ready stream toward the L0 input FIFO of the MAC array. A 2-entry output buffer absorbs the SRAM's 1-cycle read latency under downstream backpressure, so no word is lost or duplicated and full throughput is sustained when `out_ready` stays high.

---
 rtl/sram_rd_stream_pkg.sv | 21 ++
 rtl/sram_rd_stream_fifo2.sv | 47 ++++
 rtl/sram_rd_stream.sv | 130 +++++++++++++
 tb/tb_sram_rd_stream.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/sram_rd_stream_pkg.sv
// Shared types and defaults for the SRAM read streamer and its output buffer.
package sram_rd_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int BW_DEF        = 32;
  localparam int AW_DEF        = 11;
  localparam int BUF_DEPTH_DEF = 2;

  // Occupancy counter width: must hold 0..depth inclusive.
  function automatic int fill_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int FILL_W_DEF = $clog2(BUF_DEPTH_DEF + 1);

endpackage

// File: rtl/sram_rd_stream_fifo2.sv
// Small circular output buffer: push/pop, occupancy count and registered head word.
module stream_fifo2
  import sram_rd_stream_pkg::*;
#(
  parameter int W     = BW_DEF,
  parameter int DEPTH = BUF_DEPTH_DEF,
  parameter int FW    = fill_w(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [W-1:0]  push_data_i,
  input  logic          pop_i,
  output logic [FW-1:0] fill_o,
  output logic [W-1:0]  head_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [FW-1:0] fill_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      fill_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= push_data_i;
        wr_q        <= ptr_inc(wr_q);
      end
      if (pop_i) rd_q <= ptr_inc(rd_q);
      fill_q <= fill_q + FW'(push_i) - FW'(pop_i);
    end
  end

  assign fill_o = fill_q;
  assign head_o = mem_q[rd_q];

endmodule

// File: rtl/sram_rd_stream.sv
// SRAM read sequencer streaming a run of words through a credit-managed output buffer.
// Optional stall counter output enabled by defining SRAM_RD_STREAM_PERF_EN.
module sram_rd_stream
  import sram_rd_stream_pkg::*;
#(
  parameter int BW        = BW_DEF,
  parameter int AW        = AW_DEF,
  parameter int BUF_DEPTH = BUF_DEPTH_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic          sram_cen,
  output logic          sram_wen,
  output logic [AW-1:0] sram_a,
  input  logic [BW-1:0] sram_q,
  output logic [BW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
`ifdef SRAM_RD_STREAM_PERF_EN
  ,
  output logic [15:0]   perf_stall_cnt
`endif
);

  localparam int FW = fill_w(BUF_DEPTH);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   rem_q, rem_d;
  logic          inflight_q;
  logic          done_q, done_d;
  logic [FW-1:0] fill;
  logic [FW:0]   occ_next;
  logic          pop, issue;

  assign out_valid = (fill != '0);
  assign pop       = out_valid && out_ready;
  // A read may go out only if its word is guaranteed a slot when it lands.
  assign occ_next  = {1'b0, fill} + (FW+1)'(inflight_q) - (FW+1)'(pop);
  assign issue     = (state_q == RUN) && (occ_next < (FW+1)'(BUF_DEPTH));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d = base_addr;
          rem_d  = len;
          if (len == '0) done_d  = 1'b1;
          else           state_d = RUN;
        end
      end
      RUN: begin
        if (issue) begin
          addr_d = addr_q + AW'(1);
          rem_d  = rem_q - (AW+1)'(1);
          if (rem_q == (AW+1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && (fill == FW'(1)) && !inflight_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      inflight_q <= issue;
      done_q     <= done_d;
    end
  end

  stream_fifo2 #(
    .W     (BW),
    .DEPTH (BUF_DEPTH),
    .FW    (FW)
  ) u_buf (
    .clk_i       (clk),
    .rst_i       (reset),
    .push_i      (inflight_q),
    .push_data_i (sram_q),
    .pop_i       (pop),
    .fill_o      (fill),
    .head_o      (out_data)
  );

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign sram_cen = ~issue;
  assign sram_wen = 1'b1;
  assign sram_a   = addr_q;

`ifdef SRAM_RD_STREAM_PERF_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      stall_q <= '0;
    end else if ((state_q != IDLE) && out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign perf_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_sram_rd_stream.sv
// Randomized self-checking bench for sram_rd_stream against an address/queue reference model.
module tb_sram_rd_stream;

  localparam int BW    = 32;
  localparam int AW    = 11;
  localparam int WORDS = 2048;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          busy, done, sram_cen, sram_wen;
  logic [AW-1:0] sram_a;
  logic [BW-1:0] sram_q;
  logic [BW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
`ifdef SRAM_RD_STREAM_PERF_EN
  logic [15:0]   perf_stall_cnt;
`endif

  logic [BW-1:0] mem [WORDS];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sram_rd_stream dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .sram_cen  (sram_cen),
    .sram_wen  (sram_wen),
    .sram_a    (sram_a),
    .sram_q    (sram_q),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef SRAM_RD_STREAM_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always_ff @(posedge clk) if (!sram_cen) sram_q <= mem[sram_a];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic pick_ready(input int mode, input int cyc);
    if (mode == 1) return logic'($urandom_range(0, 1));
    if (mode == 2) return !(cyc >= 5 && cyc < 15);
    return 1'b1;
  endfunction

  // mode 0: always ready, 1: random ready, 2: ready low for cycles 5..14
  task automatic run(input int base, input int nw, input int mode, input bit poke);
    logic [BW-1:0] exp_q[$];
    int  n_iss = 0, n_xfer = 0, done_cyc = -1, first_v = -1, stalls = 0;
    int  budget = nw * 12 + 40;
    bit  prev_hold = 0;
    logic [BW-1:0] prev_data = '0;
    for (int i = 0; i < nw; i++) exp_q.push_back(mem[(base + i) % WORDS]);
    @(negedge clk);
    start = 1'b1; base_addr = AW'(base); len = (AW+1)'(nw); out_ready = 1'b1;
    #1;
    chk("busy_cycle0", busy, 0);
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      start = poke && (cyc == 4);
      if (start) begin base_addr = 11'h123; len = 12'd5; end
      out_ready = pick_ready(mode, cyc);
      #1;
      if (cyc == 1) chk("busy_cycle1", busy, 1);
      if (!sram_cen) begin
        chk("issue_addr", sram_a, (base + n_iss) % WORDS);
        n_iss++;
      end
      if (mode == 2 && cyc >= 7 && cyc < 15) chk("cen_while_full", sram_cen, 1);
      if (prev_hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
      end
      if (out_valid && first_v < 0) first_v = cyc;
      if (out_valid && !out_ready) stalls++;
      if (out_valid && out_ready) begin
        if (n_xfer < nw) chk("stream_data", out_data, exp_q[n_xfer]);
        else             chk("extra_transfer", n_xfer, nw);
        n_xfer++;
      end
      chk("outstanding_le2", (n_iss - n_xfer) <= 2, 1);
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      if (done) begin done_cyc = cyc; break; end
    end
    if (done_cyc < 0) chk("done_timeout", 0, 1);
    chk("issue_count", n_iss, nw);
    chk("xfer_count", n_xfer, nw);
    chk("busy_at_done", busy, 0);
    if (mode == 0) begin
      chk("first_valid_cycle", first_v, 3);
      chk("done_cycle", done_cyc, nw + 3);
    end
`ifdef SRAM_RD_STREAM_PERF_EN
    chk("perf_stall_cnt", perf_stall_cnt, stalls);
`endif
    @(negedge clk); start = 1'b0; #1;
    chk("done_one_cycle", done, 0);
  endtask

  task automatic run_len0(input int base);
    @(negedge clk);
    start = 1'b1; base_addr = AW'(base); len = '0; out_ready = 1'b1;
    #1;
    chk("len0_cen_c0", sram_cen, 1);
    @(negedge clk); start = 1'b0; #1;
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 0);
    chk("len0_cen_c1", sram_cen, 1);
    @(negedge clk); #1;
    chk("len0_done_clear", done, 0);
    chk("len0_busy_c2", busy, 0);
  endtask

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_cen"}, sram_cen, 1);
    chk({pfx, "_wen"}, sram_wen, 1);
    chk({pfx, "_a"}, sram_a, 0);
    chk({pfx, "_valid"}, out_valid, 0);
    chk({pfx, "_data"}, out_data, 0);
  endtask

  task automatic run_reset_mid(input int base);
    int dseen = 0;
    @(negedge clk);
    start = 1'b1; base_addr = AW'(base); len = 12'd8; out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); start = 1'b0;
    end
    #1;
    chk("pre_reset_valid", out_valid, 1);
    chk("pre_reset_busy", busy, 1);
    @(negedge clk); reset = 1'b1; #1;
    check_reset_vals("midrun_reset");
    @(negedge clk); reset = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (done) dseen++;
    end
    chk("no_done_after_reset", dseen, 0);
    chk("idle_after_reset", busy, 0);
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
    reset = 1'b1; start = 1'b0; base_addr = '0; len = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_vals("por");
    @(negedge clk); reset = 1'b0;

    run(32'h010, 4, 0, 0);
    run(32'h7FE, 4, 0, 0);
    run($urandom_range(0, WORDS - 1), 16, 1, 1);
    run(32'h100, 16, 2, 0);
    run_len0(32'h055);
    run_reset_mid(32'h200);
    run(32'h020, 4, 0, 0);
    for (int k = 0; k < 4; k++) run($urandom_range(0, WORDS - 1), $urandom_range(1, 40), 1, 0);
    run(32'h3A5, 2048, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
